// File: rtl/deser_pkg.sv
// Shared helpers for the lane-array deserializer: phase counter width, the
// flat slot/lane indexing of the output word, and the output register actions.
package deser_pkg;

  typedef enum logic [1:0] {
    OUT_HOLD,
    OUT_LOAD,
    OUT_DROP,
    OUT_CLEAR
  } out_action_e;

  function automatic int phase_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Word element index of slot k, lane l; multiply by WIDTH for the bit offset.
  function automatic int flat_idx(input int slot, input int lane, input int lanes);
    return slot * lanes + lane;
  endfunction

endpackage

// File: rtl/deser_lane.sv
// One lane of the deserializer: RATIO-1 gather registers plus the live sample
// that closes the word, presented as a RATIO-slot combinational word.
module deser_lane #(
  parameter int WIDTH = 9,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATIO-2:0]       slot_en,
  input  logic [WIDTH-1:0]       in_sample,
  output logic [RATIO*WIDTH-1:0] word
);

  logic [WIDTH-1:0] slot_q [RATIO-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the gather registers are reset because a word completed after a
  // non-zero phase_init exposes the slots that were never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RATIO-1; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < RATIO-1; k++) begin
        if (slot_en[k]) slot_q[k] <= in_sample;
      end
    end
  end

  for (genvar k = 0; k < RATIO-1; k++) begin : g_slot
    assign word[k*WIDTH +: WIDTH] = slot_q[k];
  end
  assign word[(RATIO-1)*WIDTH +: WIDTH] = in_sample;

endmodule

// File: rtl/deser_array.sv
// Lane-array deserializer: gathers RATIO valid samples per lane into one word,
// with valid gating, word-boundary slip and a single-entry ready/valid output.
module deser_array
  import deser_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 9,
  parameter int RATIO = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [phase_w(RATIO)-1:0]     phase_init,
  input  logic [LANES*WIDTH-1:0]        in_data,
  input  logic                          in_valid,
  input  logic                          slip,
  output logic [RATIO*LANES*WIDTH-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [phase_w(RATIO)-1:0]     phase,
  output logic                          overflow
);

  localparam int PW = phase_w(RATIO);
  localparam int OW = RATIO * LANES * WIDTH;
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

  logic [PW-1:0]    phase_q;
  logic             slip_pending_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic [OW-1:0]    out_data_q;
  logic             discard, accept, complete;
  logic [RATIO-2:0] slot_en;
  logic [OW-1:0]    word;
  out_action_e      action;

  // A pending or same-cycle slip swallows exactly one valid sample.
  assign discard  = in_valid && (slip || slip_pending_q);
  assign accept   = in_valid && !discard;
  assign complete = accept && (phase_q == LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    slot_en = '0;
    for (int k = 0; k < RATIO-1; k++) begin
      slot_en[k] = accept && (phase_q == PW'(k));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [RATIO*WIDTH-1:0] lane_word;

    deser_lane #(
      .WIDTH (WIDTH),
      .RATIO (RATIO)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .slot_en   (slot_en),
      .in_sample (in_data[l*WIDTH +: WIDTH]),
      .word      (lane_word)
    );

    for (genvar k = 0; k < RATIO; k++) begin : g_slot
      assign word[flat_idx(k, l, LANES)*WIDTH +: WIDTH] = lane_word[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    action = OUT_HOLD;
    if (complete) begin
      action = (out_valid_q && !out_ready) ? OUT_DROP : OUT_LOAD;
    end else if (out_valid_q && out_ready) begin
      action = OUT_CLEAR;
    end
  end

  // phase_init is held static while rst is high, so the async load is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= phase_init;
      slip_pending_q <= 1'b0;
      out_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      out_data_q     <= '0;
    end else begin
      if (accept) phase_q <= (phase_q == LAST) ? '0 : phase_q + 1'b1;

      if (discard)   slip_pending_q <= 1'b0;
      else if (slip) slip_pending_q <= 1'b1;

      case (action)
        OUT_LOAD: begin
          out_data_q  <= word;
          out_valid_q <= 1'b1;
        end
        OUT_DROP:  overflow_q  <= 1'b1;
        OUT_CLEAR: out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_deser_array.sv
// Bench for deser_array: vector table, directed slip/overflow/phase_init/reset
// sequences, and randomized traffic scored against a sample-history model.
module tb_deser_array;
  import deser_pkg::*;

  localparam int LANES = 8;
  localparam int WIDTH = 9;
  localparam int RATIO = 4;
  localparam int PW    = phase_w(RATIO);
  localparam int IW    = LANES * WIDTH;
  localparam int OW    = RATIO * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] phase_init;
  logic [IW-1:0] in_data;
  logic          in_valid, slip, out_ready;
  logic [OW-1:0] out_data;
  logic          out_valid, overflow;
  logic [PW-1:0] phase;

  deser_array #(.LANES(LANES), .WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .phase_init (phase_init),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .slip       (slip),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .phase      (phase),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every sample accepted since reset, in order.
  logic [IW-1:0] hist [$];
  logic          m_pend, m_valid, m_ovf;
  logic [OW-1:0] m_data;

  function automatic int m_phase();
    return (int'(phase_init) + hist.size()) % RATIO;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_data  = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic r, input logic [IW-1:0] d);
    bit            acc, done;
    logic [OW-1:0] w;
    acc  = v && !s && !m_pend;
    done = acc && (m_phase() == RATIO-1);
    if (v && (s || m_pend)) m_pend = 1'b0;
    else if (s)             m_pend = 1'b1;
    if (acc) hist.push_back(d);
    if (done) begin
      w = '0;
      for (int k = 0; k < RATIO; k++) begin
        int            i;
        logic [IW-1:0] smp;
        i   = hist.size() - RATIO + k;
        smp = (i >= 0) ? hist[i] : '0;
        for (int l = 0; l < LANES; l++)
          w[flat_idx(k, l, LANES)*WIDTH +: WIDTH] = smp[l*WIDTH +: WIDTH];
      end
      if (m_valid && !r) m_ovf = 1'b1;
      else begin
        m_data  = w;
        m_valid = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("cmp_valid", out_valid, m_valid);
    check("cmp_phase", phase, m_phase());
    check("cmp_overflow", overflow, m_ovf);
    check("cmp_data", out_data, m_data);
  endtask

  // Sample n on lane l is (n*LANES + l) mod 2^WIDTH.
  function automatic logic [IW-1:0] seq_sample(input int n);
    logic [IW-1:0] s;
    for (int l = 0; l < LANES; l++)
      s[l*WIDTH +: WIDTH] = WIDTH'((n * LANES + l) % (1 << WIDTH));
    return s;
  endfunction

  // Word whose first `zeros` slots are 0 and the rest hold samples first, first+1, ...
  function automatic logic [OW-1:0] seq_word(input int first, input int zeros);
    logic [OW-1:0] w;
    for (int k = 0; k < RATIO; k++)
      for (int l = 0; l < LANES; l++)
        w[flat_idx(k, l, LANES)*WIDTH +: WIDTH] = (k < zeros) ? '0 :
          WIDTH'(((first + k - zeros) * LANES + l) % (1 << WIDTH));
    return w;
  endfunction

  function automatic logic [IW-1:0] rand_sample();
    logic [IW-1:0] s;
    for (int l = 0; l < LANES; l++) s[l*WIDTH +: WIDTH] = WIDTH'($urandom);
    return s;
  endfunction

  task automatic cycle(input logic v, input logic s, input logic r, input logic [IW-1:0] d);
    in_valid  = v;
    slip      = s;
    out_ready = r;
    in_data   = d;
    @(posedge clk);
    model_step(v, s, r, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic [PW-1:0] p);
    phase_init = p;
    in_valid   = 1'b0;
    slip       = 1'b0;
    out_ready  = 1'b1;
    in_data    = '0;
    rst        = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit do_rst;
    bit v;
    bit exp_valid;
    int exp_phase;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int sn;
    rst        = 1'b0;
    phase_init = '0;
    in_valid   = 1'b0;
    slip       = 1'b0;
    out_ready  = 1'b1;
    in_data    = '0;
    model_reset();
    #2;

    // Continuous valid, then 1010 valid gating on the same data sequence.
    for (int i = 0; i < 12; i++)
      vecs.push_back('{do_rst: (i == 0), v: 1'b1, exp_valid: (i % 4 == 3), exp_phase: (i + 1) % 4});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{do_rst: (i == 0), v: (i % 2 == 0), exp_valid: (i % 8 == 6), exp_phase: (i / 2 + 1) % 4});

    sn = 0;
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) begin
        do_reset('0);
        sn = 0;
      end
      cycle(vecs[i].v, 1'b0, 1'b1, vecs[i].v ? seq_sample(sn) : ~seq_sample(sn));
      if (vecs[i].v) sn++;
      check("tbl_valid", out_valid, vecs[i].exp_valid);
      check("tbl_phase", phase, vecs[i].exp_phase);
      if (vecs[i].exp_valid) check("tbl_word", out_data, seq_word(sn - 4, 0));
    end

    // Slip: two back-to-back requests drop one sample; slip with valid drops that sample.
    do_reset('0);
    for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, 1'b1, seq_sample(n));
    check("slip_w1", out_data, seq_word(0, 0));
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b1, seq_sample(4));
    check("slip_drop_phase", phase, 0);
    for (int n = 5; n < 9; n++) cycle(1'b1, 1'b0, 1'b1, seq_sample(n));
    check("slip_w2_valid", out_valid, 1);
    check("slip_w2", out_data, seq_word(5, 0));
    cycle(1'b1, 1'b1, 1'b1, seq_sample(9));
    check("slip_same_phase", phase, 0);
    for (int n = 10; n < 14; n++) cycle(1'b1, 1'b0, 1'b1, seq_sample(n));
    check("slip_w3", out_data, seq_word(10, 0));

    // Backpressure: held word, overflow on second completion, then recovery.
    do_reset('0);
    for (int n = 0; n < 10; n++) begin
      cycle(1'b1, 1'b0, 1'b0, seq_sample(n));
      if (n == 3) check("ov_w1", out_data, seq_word(0, 0));
      if (n == 6) check("ov_not_yet", overflow, 0);
      if (n == 7) check("ov_set", overflow, 1);
    end
    check("ov_held_valid", out_valid, 1);
    check("ov_held_data", out_data, seq_word(0, 0));
    cycle(1'b1, 1'b0, 1'b1, seq_sample(10));
    check("ov_drain", out_valid, 0);
    cycle(1'b1, 1'b0, 1'b1, seq_sample(11));
    check("ov_w3_valid", out_valid, 1);
    check("ov_w3", out_data, seq_word(8, 0));
    check("ov_sticky", overflow, 1);

    // phase_init = 2: first word after two samples, slots 0..1 zero.
    do_reset(PW'(2));
    check("pi_phase", phase, 2);
    cycle(1'b1, 1'b0, 1'b1, seq_sample(0));
    check("pi_no_word", out_valid, 0);
    cycle(1'b1, 1'b0, 1'b1, seq_sample(1));
    check("pi_valid", out_valid, 1);
    check("pi_word", out_data, seq_word(0, 2));
    for (int n = 2; n < 6; n++) cycle(1'b1, 1'b0, 1'b1, seq_sample(n));
    check("pi_w2", out_data, seq_word(2, 0));

    // Reset mid-word with a held word and overflow: outputs drop without a clock edge.
    do_reset('0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, 1'b0, seq_sample(n));
    check("mr_pre_phase", phase, 2);
    check("mr_pre_valid", out_valid, 1);
    check("mr_pre_ovf", overflow, 1);
    rst = 1'b1;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_ovf", overflow, 0);
    check("mr_phase", phase, 0);
    check("mr_data", out_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 1'b0, 1'b1, seq_sample(20 + n));
      check("mr_partial", out_valid, 0);
    end
    cycle(1'b1, 1'b0, 1'b1, seq_sample(23));
    check("mr_full_valid", out_valid, 1);
    check("mr_full", out_data, seq_word(20, 0));

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset(PW'($urandom_range(0, RATIO - 1)));
      for (int c = 0; c < 300; c++)
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 6, rand_sample());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deser_array.md
# deser_array

Parametrised lane-array deserializer that gathers RATIO consecutive valid samples on each of LANES parallel WIDTH-bit lanes into one wide word. It sits between the ADC sample front-end and the DSP/FIFO domain. It generalises the fixed 8×9-bit, 1:4 deserializer with three additions: input valid gating, runtime word-boundary slip, and a ready/valid output with overflow detection.

## Interface
Parameters:
- LANES, 8, number of parallel input lanes
- WIDTH, 9, bits per sample
- RATIO, 4, samples per lane per output word (≥2)

Ports:
- clk  in  1  sample clock
- rst  in  1  reset, asynchronous, active-high
- phase_init  in  clog2(RATIO)  phase loaded during reset; must be static while rst is high
- in_data  in  LANES*WIDTH  lane l at [l*WIDTH +: WIDTH]
- in_valid  in  1  in_data holds a new sample on all lanes
- slip  in  1  single-cycle request to move the word boundary by one sample
- out_data  out  RATIO*LANES*WIDTH  slot k, lane l at [(k*LANES+l)*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts out_data
- phase  out  clog2(RATIO)  current slot index
- overflow  out  1  sticky; a completed word was dropped

## Operation
- Slot counter phase: an accepted sample (in_valid high and not discarded) is written to slot phase of every lane, then phase increments modulo RATIO.
- Completion: an accepted sample with phase == RATIO-1 completes a word. The word is slots 0..RATIO-2 from the gather registers plus the current in_data in slot RATIO-1.
- Slip:
  - A slip pulse sets slip_pending.
  - The next in_valid sample is discarded: no slot write, phase unchanged, and slip_pending clears.
  - slip together with in_valid in the same cycle discards that same sample.
  - slip asserted while slip_pending is already set is ignored, so slips are not cumulative.
  - RATIO slips are needed to return to the original alignment.
- Output register (single entry):
  - Completion while out_valid is low, or while out_valid && out_ready: load out_data, set out_valid.
  - Completion while out_valid && !out_ready: the new word is dropped, out_data is unchanged, overflow is set.
  - out_valid && out_ready without completion: clear out_valid.
- overflow clears only on rst.
- Samples are stored unmodified; there is no arithmetic on data.

## Timing
- Reset values: phase = phase_init, slip_pending = 0, out_valid = 0, out_data = 0, overflow = 0, gather registers = 0.
- Latency: the word appears, with out_valid high, on the clock edge that samples the completing input, i.e. one cycle after that input is presented.
- Throughput: one word per RATIO accepted samples. With in_valid always high and out_ready always high, out_valid is high one cycle in every RATIO.
- Gaps in in_valid stall phase without losing stored slots.
- rst mid-word: the partial word is discarded and phase is reloaded. An out_valid word not yet taken is lost (out_valid = 0).
- With phase_init = p, the first completion occurs after RATIO-p accepted samples.

## Structure
- Package deser_pkg:
  - PHASE_W = $clog2(RATIO) helper function
  - slot/lane flat-index function used by RTL and bench
- Sub-module deser_lane, instantiated LANES times:
  - RATIO-1 slot registers for one lane, written by a shared one-hot slot enable
  - combinational full-word output, including the live in_data for the final slot
- Top level holds the phase counter, slip_pending, the output register and overflow.

## Test plan
- Default params, phase_init = 0, in_valid = 1, lane l sample n = (n*8+l) mod 512, out_ready = 1:
  - first word: slot k lane l = k*8+l
  - out_valid pulses on cycles 4, 8, 12…
- in_valid toggling 1010…: the same data sequence yields identical words, with out_valid every 8 cycles.
- slip pulse after the first word:
  - the next sample is dropped
  - the second word begins with sample 5
  - phase is unchanged across the dropped cycle
  - two slips in consecutive cycles drop only one sample
- out_ready = 0 for 10 cycles:
  - first word held stable
  - second completion sets overflow and out_data is unchanged
  - after out_ready returns to 1, out_valid deasserts, then the third word loads
- phase_init = 2: first out_valid after 2 accepted samples, holding 0 in slots 0–1.
- rst asserted mid-word (phase = 2) with out_valid = 1: out_valid, overflow and phase drop immediately, without waiting for a clock edge. After release, a full RATIO samples are needed for the next word.
